// File: rtl/dma_read_checker_if.sv
// dma_read_checker_if: read-command and read-data channels between the checker and the DMA engine
interface dma_read_checker_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int DATA_WIDTH = 512
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_address;
  logic [LEN_WIDTH-1:0]    cmd_length;
  logic                    data_valid;
  logic                    data_ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] keep;
  logic                    last;
  modport master (
    output cmd_valid, cmd_address, cmd_length, data_ready,
    input  cmd_ready, data_valid, data, keep, last
  );
  modport slave (
    input  cmd_valid, cmd_address, cmd_length, data_ready,
    output cmd_ready, data_valid, data, keep, last
  );
endinterface

// File: rtl/dma_read_checker.sv
// dma_read_checker: issues one DMA read per start edge and checks returned beats against an incrementing pattern
module dma_read_checker #(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  pcie_clk,
  input  logic                  pcie_areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_length,
  input  logic [31:0]           cfg_offset,
  dma_read_checker_if.master    dma,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic                  last_err,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  error_cnt,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic [CNT_WIDTH-1:0]  cycle_cnt
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_n;
  logic start_q, launch, zero_len, cmd_fire, accept, final_beat, mismatch;
  logic [LEN_WIDTH-1:0] beats;
  logic [31:0] offset, expect_lo;
  assign launch     = start & ~start_q & (state == IDLE);
  assign zero_len   = ~|cfg_length[LEN_WIDTH-1:6];
  assign cmd_fire   = (state == CMD) & dma.cmd_valid & dma.cmd_ready;
  assign accept     = dma.data_valid & dma.data_ready;
  assign final_beat = LEN_WIDTH'(beat_cnt) == beats - LEN_WIDTH'(1);
  assign expect_lo  = 32'(beat_cnt) + offset;
  assign mismatch   = (dma.data[31:0] != expect_lo) | (|dma.data[DATA_WIDTH-1:32]) | ~&dma.keep;
  assign busy       = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((launch && !zero_len) ? CMD : IDLE) :
              (state == CMD)  ? (cmd_fire ? DATA : CMD) :
              (accept && final_beat) ? IDLE : DATA;
  end
  always_ff @(posedge pcie_clk or posedge pcie_areset)
    if (pcie_areset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= start;
    end
  // Handshake outputs follow the next state so they are registered yet aligned with it
  always_ff @(posedge pcie_clk or posedge pcie_areset)
    if (pcie_areset) begin
      dma.cmd_valid   <= 1'b0;
      dma.data_ready  <= 1'b0;
      dma.cmd_address <= '0;
      dma.cmd_length  <= '0;
      beats           <= '0;
      offset          <= '0;
      done            <= 1'b0;
      len_err         <= 1'b0;
      last_err        <= 1'b0;
      beat_cnt        <= '0;
      error_cnt       <= '0;
      first_err_index <= '1;
      cycle_cnt       <= '0;
    end else begin
      dma.cmd_valid  <= state_n == CMD;
      dma.data_ready <= state_n == DATA;
      if (launch) begin
        dma.cmd_address <= cfg_addr;
        dma.cmd_length  <= {cfg_length[LEN_WIDTH-1:6], 6'b0};
        beats           <= cfg_length >> 6;
        offset          <= cfg_offset;
        done            <= zero_len;
        len_err         <= zero_len;
        last_err        <= 1'b0;
        beat_cnt        <= '0;
        error_cnt       <= '0;
        first_err_index <= '1;
        cycle_cnt       <= '0;
      end
      if (cmd_fire || state == DATA) cycle_cnt <= cycle_cnt + 1'b1;
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (mismatch && !(&error_cnt)) error_cnt <= error_cnt + 1'b1;
        if (mismatch && &first_err_index) first_err_index <= beat_cnt;
        if (dma.last != final_beat) last_err <= 1'b1;
        if (final_beat) done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dma_read_checker.sv
// tb_dma_read_checker: directed checks of command issue, beat checking, sticky flags and reset abort
module tb_dma_read_checker;
  localparam int DW = 512;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] cfg_addr = '0;
  logic [31:0] cfg_length = '0, cfg_offset = '0;
  logic busy, done, len_err, last_err;
  logic [31:0] beat_cnt, error_cnt, first_err_index, cycle_cnt;
  int compared = 0, mismatched = 0;
  logic [31:0] lo [64];
  logic kb [64], hb [64], lst [64];
  dma_read_checker_if #(.ADDR_WIDTH(64), .LEN_WIDTH(32), .DATA_WIDTH(DW)) dma ();
  dma_read_checker dut (
    .pcie_clk(clk), .pcie_areset(rst), .start(start), .cfg_addr(cfg_addr),
    .cfg_length(cfg_length), .cfg_offset(cfg_offset), .dma(dma.master),
    .busy(busy), .done(done), .len_err(len_err), .last_err(last_err),
    .beat_cnt(beat_cnt), .error_cnt(error_cnt), .first_err_index(first_err_index),
    .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input int n, input logic [31:0] off);
    for (int i = 0; i < 64; i++) begin
      lo[i]  = off + 32'(i);
      kb[i]  = 1'b0;
      hb[i]  = 1'b0;
      lst[i] = (i == n - 1);
    end
  endtask
  task automatic launch(input logic [31:0] len, input logic [31:0] off, input logic [63:0] addr, input int dly);
    logic [31:0] el;
    el = len & 32'hFFFF_FFC0;
    @(negedge clk);
    cfg_addr = addr; cfg_length = len; cfg_offset = off; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cmd_valid_rise", dma.cmd_valid, 1);
    chk("busy_rise", busy, 1);
    chk("cmd_address", dma.cmd_address, addr);
    chk("cmd_length", dma.cmd_length, el);
    chk("data_ready_cmd", dma.data_ready, 0);
    for (int k = 0; k < dly; k++) begin
      dma.cmd_ready = 1'b0; dma.data_valid = 1'b1; cfg_addr = ~addr; cfg_length = 32'h40;
      @(negedge clk);
      chk("cmd_valid_hold", dma.cmd_valid, 1);
      chk("cmd_address_hold", dma.cmd_address, addr);
      chk("cmd_length_hold", dma.cmd_length, el);
      chk("data_ready_stall", dma.data_ready, 0);
      chk("beat_cnt_stall", beat_cnt, 0);
    end
    dma.data_valid = 1'b0; dma.cmd_ready = 1'b1;
    @(negedge clk);
    dma.cmd_ready = 1'b0;
    chk("data_ready_rise", dma.data_ready, 1);
    chk("cmd_valid_drop", dma.cmd_valid, 0);
  endtask
  task automatic beats(input int n, input bit poke);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = '0; d[31:0] = lo[i]; d[DW-1] = hb[i];
      dma.data = d;
      dma.keep = kb[i] ? {{63{1'b1}}, 1'b0} : '1;
      dma.last = lst[i];
      dma.data_valid = 1'b1;
      if (poke) start = (i == 1);
      @(negedge clk);
      if (i < n - 1) begin
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
        chk("beat_cnt_mid", beat_cnt, 32'(i + 1));
      end
    end
    dma.data_valid = 1'b0; dma.last = 1'b0; start = 1'b0;
  endtask
  task automatic finish(input int n, input logic [31:0] err, input logic [31:0] fei, input logic le);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("beat_cnt", beat_cnt, 32'(n));
    chk("error_cnt", error_cnt, err);
    chk("first_err_index", first_err_index, fei);
    chk("last_err", last_err, le);
    chk("len_err", len_err, 0);
    chk("cycle_cnt", cycle_cnt, 32'(n + 1));
    chk("data_ready_end", dma.data_ready, 0);
    chk("cmd_valid_end", dma.cmd_valid, 0);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_last_err"}, last_err, 0);
    chk({tag, "_cmd_valid"}, dma.cmd_valid, 0);
    chk({tag, "_data_ready"}, dma.data_ready, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
    chk({tag, "_error_cnt"}, error_cnt, 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_fei"}, first_err_index, 32'hFFFF_FFFF);
  endtask
  initial begin
    dma.cmd_ready = 1'b0; dma.data_valid = 1'b0; dma.data = '0; dma.keep = '0; dma.last = 1'b0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 1'b0;
    // clean 64-beat read
    fill(64, 32'h100);
    launch(4096, 32'h100, 64'h0000_0001_0000_1000, 0);
    beats(64, 0);
    finish(64, 0, 32'hFFFF_FFFF, 0);
    // corrupted low word on beat 3, cleared keep bit on beat 5
    fill(8, 0);
    lo[3] = 32'd7; kb[5] = 1'b1;
    launch(512, 0, 64'h2000, 0);
    beats(8, 0);
    finish(8, 2, 3, 0);
    // nonzero upper bits on beat 0
    fill(2, 32'd5);
    hb[0] = 1'b1;
    launch(128, 32'd5, 64'h3000, 0);
    beats(2, 0);
    finish(2, 1, 0, 0);
    // last on beats 1 and 3
    fill(4, 0);
    lst[1] = 1'b1;
    launch(256, 0, 64'h4000, 0);
    beats(4, 0);
    finish(4, 0, 32'hFFFF_FFFF, 1);
    // command backpressure, offered data not taken before the handshake
    fill(2, 32'h55);
    launch(128, 32'h55, 64'hABCD_0000_0000_5000, 10);
    beats(2, 0);
    finish(2, 0, 32'hFFFF_FFFF, 0);
    // short length
    @(negedge clk);
    cfg_length = 63; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("short_done", done, 1);
    chk("short_len_err", len_err, 1);
    chk("short_busy", busy, 0);
    chk("short_cmd_valid", dma.cmd_valid, 0);
    @(negedge clk);
    chk("short_no_cmd", dma.cmd_valid, 0);
    // length 200 truncates to 3 beats, second start during DATA ignored
    fill(3, 32'h9);
    launch(200, 32'h9, 64'h6000, 0);
    chk("len_err_clear", len_err, 0);
    beats(3, 1);
    finish(3, 0, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    chk("restart_ignored_busy", busy, 0);
    chk("restart_ignored_cmd", dma.cmd_valid, 0);
    // reset mid-DATA
    fill(4, 0);
    launch(256, 0, 64'h7000, 0);
    beats(2, 0);
    dma.data_valid = 1'b1; dma.data = '0; dma.keep = '1;
    rst = 1'b1;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_data_ready", dma.data_ready, 0);
    @(negedge clk);
    reset_vals("areset");
    dma.data_valid = 1'b0;
    rst = 1'b0;
    // fresh start after reset, offset wraps through zero
    fill(4, 32'hFFFF_FFFE);
    chk("wrap_model", lo[2], 32'h0);
    launch(256, 32'hFFFF_FFFE, 64'h8000, 0);
    beats(4, 0);
    finish(4, 0, 32'hFFFF_FFFF, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dma_read_checker.md
# dma_read_checker

Self-checking DMA read engine for the PCIe/XDMA path. On a start request it issues one read command on a `dma_inf` read-command channel, sinks the returned 512-bit beats from the matching read-data stream, and compares every beat against the incrementing pattern produced by the DMA write test generator (`beat_index + offset` in the low 32 bits, upper bits zero). It sits beside that generator on channel 1 in the XDMA example top; `fpga_control_reg` drives its control inputs and its results feed `fpga_status_reg`.

## Interface
- ADDR_WIDTH, 64, host address width
- LEN_WIDTH, 32, byte-length width
- DATA_WIDTH, 512, data-beat width; keep width is DATA_WIDTH/8
- CNT_WIDTH, 32, width of all status counters
- pcie_clk  in  1  single clock for all logic
- pcie_areset  in  1  reset, asynchronous assert, active-high
- start  in  1  level; each rising edge launches one check
- cfg_addr  in  ADDR_WIDTH  host buffer address
- cfg_length  in  LEN_WIDTH  bytes to read
- cfg_offset  in  32  pattern base value
- m_axis_dma_read_cmd_valid / _ready  out / in  1  command handshake
- m_axis_dma_read_cmd_address  out  ADDR_WIDTH  latched cfg_addr
- m_axis_dma_read_cmd_length  out  LEN_WIDTH  latched beats*64
- s_axis_dma_read_data_valid / _ready  in / out  1  data handshake
- s_axis_dma_read_data_data  in  DATA_WIDTH  beat payload
- s_axis_dma_read_data_keep  in  DATA_WIDTH/8  byte enables
- s_axis_dma_read_data_last  in  1  end of transfer
- busy  out  1  check in progress
- done  out  1  sticky; set when a check ends, cleared at next launch
- len_err  out  1  sticky; last launch had length < 64
- last_err  out  1  sticky; `last` position wrong in last check
- beat_cnt  out  CNT_WIDTH  beats accepted in current/last check
- error_cnt  out  CNT_WIDTH  mismatching beats; saturates at all-ones
- first_err_index  out  CNT_WIDTH  index of first mismatching beat; all-ones if none
- cycle_cnt  out  CNT_WIDTH  cycles from command handshake to final beat, inclusive

## Operation
- States are IDLE, CMD and DATA.
- A start edge is `start & ~start_q`, where `start_q` is a register. Edges seen outside IDLE are ignored.
- Launch in IDLE:
  - latch address, offset and `beats = cfg_length >> 6`
  - clear done, last_err, beat_cnt, error_cnt and cycle_cnt
  - set first_err_index to all-ones
  - if `beats == 0`: set len_err and done, stay in IDLE, issue no command; otherwise clear len_err and go to CMD
- CMD:
  - cmd_valid is high
  - address and length are stable until the handshake
  - on valid & ready, go to DATA
- DATA:
  - data_ready is high
  - each accepted beat at index i (i = beat_cnt before increment) is a mismatch if `data[31:0] != i + offset` (mod 2^32), or `data[DATA_WIDTH-1:32] != 0`, or keep is not all-ones
  - a mismatch increments error_cnt, and records i into first_err_index if it is still all-ones
  - `last` must be high exactly on beat `beats-1`; any other position sets last_err
  - the transfer ends after exactly `beats` beats regardless of `last`
  - on the final beat: return to IDLE, set done, clear busy
- busy equals (state != IDLE).
- data_ready is 0 in IDLE and CMD. Beats offered there are not accepted.
- cycle_cnt increments every DATA cycle, and on the CMD handshake cycle.

## Timing
- Reset values:
  - state IDLE
  - cmd_valid 0, data_ready 0, busy 0
  - done 0, len_err 0, last_err 0
  - all counters 0, first_err_index all-ones
  - start_q 0
- Reset asserted mid-transfer aborts immediately with no pending command; a command already accepted downstream is not tracked.
- If start rises on cycle N, cmd_valid and busy are high from N+1.
- cmd_valid and data_ready are registered outputs, with no combinational path from the ready inputs.
- data_ready rises the cycle after the command handshake.
- One beat is accepted per cycle, with no bubbles while valid stays high.
- done and the final counter values are visible the cycle after the final beat. busy drops on that same cycle.
- cmd_length equals `beats << 6`: low 6 bits are truncated and the upper bits are unchanged.

## Test plan
- Clean read: length 4096, offset 0x100, beats carry 0x100..0x13F, last on beat 63, ready always high → one command (length 4096); done=1, beat_cnt=64, error_cnt=0, last_err=0, first_err_index=0xFFFFFFFF.
- Corrupted beats: length 512, offset 0; beat 3 = 7 and beat 5 has keep bit 0 cleared → error_cnt=2, first_err_index=3.
- Last misplacement: length 256, last on beat 1 and again on beat 3 → last_err=1, beat_cnt=4, done after beat 3.
- Backpressure and short length:
  - cmd_ready held low 10 cycles → address and length are held constant, data_ready stays 0
  - length 63 → no command, done=1, len_err=1
  - length 200 → command length 192, 3 beats
- Robustness:
  - second start edge during DATA → ignored
  - pcie_areset pulsed mid-DATA → all outputs at reset values the next cycle
  - fresh start after reset → completes cleanly
- Offset wrap: offset 0xFFFFFFFE, length 256 → expected low words 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; error_cnt=0.
